sc_lives_control: RTL

Game-state and lives controller sitting directly downstream of the collision comparator. Consumes its registered-level collision flag plus the frog's home-row arrival, decrements lives with a post-hit hold-off, counts frogs brought home, and produces the LOSE/WIN status codes fed back to the comparator to mask collisions when the game has ended. Also issues the one-cycle respawn pulse to the frog position register.

---
 rtl/sc_lives_control_pkg.sv | 21 ++
 rtl/sc_holdoff_counter.sv | 43 ++++
 rtl/sc_lives_control.sv | 137 +++++++++++++
 3 files changed

// File: rtl/sc_lives_control_pkg.sv
// Shared definitions for the lives/game-state controller and the collision comparator
// that decodes its LOSE/WIN status codes.
package sc_lives_control_pkg;

    localparam int LIVES_W = 3;
    localparam int WIN_W   = 4;
    localparam int LOSE_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PLAY    = 3'd1,
        ST_HIT     = 3'd2,
        ST_OVER    = 3'd3,
        ST_VICTORY = 3'd4
    } state_t;

    localparam logic [LOSE_W-1:0] LOSE_PLAY = 3'b000;
    localparam logic [LOSE_W-1:0] LOSE_HIT  = 3'b001;
    localparam logic [LOSE_W-1:0] LOSE_OVER = 3'b010;

endpackage

// File: rtl/sc_holdoff_counter.sv
// Tick-gated saturating hold-off counter; done fires on the tick that reaches HOLDOFF_TICKS.
module sc_holdoff_counter
    import sc_lives_control_pkg::*;
#(
    parameter int HOLDOFF_TICKS = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic tick,
    input  logic clear,
    output logic done
);

    localparam int CNT_W = $clog2(HOLDOFF_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HOLDOFF_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLDOFF_TICKS - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             step;

    assign step = enable && tick;
    assign done = step && (count_q == CNT_LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (step && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sc_lives_control.sv
// Game-state and lives controller: tracks lives, frogs home and the post-hit hold-off,
// and produces the LOSE/WIN status plus a one-cycle respawn pulse. All outputs registered.
module sc_lives_control
    import sc_lives_control_pkg::*;
#(
    parameter int LIVES_INIT    = 3,
    parameter int HOLDOFF_TICKS = 50,
    parameter int WIN_TARGET    = 3
) (
    input  logic               SC_LIVES_CLOCK_50,
    input  logic               SC_LIVES_RESET_InHigh,
    input  logic               SC_LIVES_COLLISION_InHigh,
    input  logic               SC_LIVES_HOME_InHigh,
    input  logic               SC_LIVES_TICK_InHigh,
    input  logic               SC_LIVES_START_InHigh,
    output logic [LOSE_W-1:0]  SC_LIVES_LOSE,
    output logic [WIN_W-1:0]   SC_LIVES_WIN,
    output logic [LIVES_W-1:0] SC_LIVES_LIVES,
    output logic               SC_LIVES_RESPAWN_InHigh
);

    localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);
    localparam logic [WIN_W-1:0]   WIN_GOAL   = WIN_W'(WIN_TARGET);

    state_t               state_q,   state_d;
    logic [LIVES_W-1:0]   lives_q,   lives_d;
    logic [WIN_W-1:0]     win_q,     win_d;
    logic [LOSE_W-1:0]    lose_q,    lose_d;
    logic                 respawn_q, respawn_d;

    logic                 hold_clear;
    logic                 hold_done;
    logic [WIN_W-1:0]     win_inc;

    assign win_inc = win_q + 1'b1;

    sc_holdoff_counter #(
        .HOLDOFF_TICKS(HOLDOFF_TICKS)
    ) u_holdoff (
        .clk   (SC_LIVES_CLOCK_50),
        .reset (SC_LIVES_RESET_InHigh),
        .enable(state_q == ST_HIT),
        .tick  (SC_LIVES_TICK_InHigh),
        .clear (hold_clear),
        .done  (hold_done)
    );

    // Collision outranks HOME in PLAY; a tick in the hit-entry cycle is dropped by the clear.
    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        win_d      = win_q;
        lose_d     = lose_q;
        respawn_d  = 1'b0;
        hold_clear = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (SC_LIVES_START_InHigh) begin
                    state_d   = ST_PLAY;
                    lives_d   = LIVES_LOAD;
                    win_d     = '0;
                    lose_d    = LOSE_PLAY;
                    respawn_d = 1'b1;
                end
            end

            ST_PLAY: begin
                if (SC_LIVES_COLLISION_InHigh) begin
                    if (lives_q > LIVES_W'(1)) begin
                        state_d    = ST_HIT;
                        lives_d    = lives_q - 1'b1;
                        lose_d     = LOSE_HIT;
                        respawn_d  = 1'b1;
                        hold_clear = 1'b1;
                    end else begin
                        state_d = ST_OVER;
                        lives_d = '0;
                        lose_d  = LOSE_OVER;
                    end
                end else if (SC_LIVES_HOME_InHigh) begin
                    if (win_inc >= WIN_GOAL) begin
                        state_d = ST_VICTORY;
                        win_d   = WIN_GOAL;
                    end else begin
                        win_d     = win_inc;
                        respawn_d = 1'b1;
                    end
                end
            end

            ST_HIT: begin
                if (hold_done) begin
                    state_d    = ST_PLAY;
                    lose_d     = LOSE_PLAY;
                    hold_clear = 1'b1;
                end
            end

            ST_OVER, ST_VICTORY: begin
                if (SC_LIVES_START_InHigh) begin
                    state_d   = ST_PLAY;
                    lives_d   = LIVES_LOAD;
                    win_d     = '0;
                    lose_d    = LOSE_PLAY;
                    respawn_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge SC_LIVES_CLOCK_50) begin
        if (SC_LIVES_RESET_InHigh) begin
            state_q   <= ST_IDLE;
            lives_q   <= LIVES_LOAD;
            win_q     <= '0;
            lose_q    <= LOSE_PLAY;
            respawn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            win_q     <= win_d;
            lose_q    <= lose_d;
            respawn_q <= respawn_d;
        end
    end

    assign SC_LIVES_LOSE           = lose_q;
    assign SC_LIVES_WIN            = win_q;
    assign SC_LIVES_LIVES          = lives_q;
    assign SC_LIVES_RESPAWN_InHigh = respawn_q;

endmodule
